aux_native_ctrl: RTL and testbench

// - AUX CTRL unit native-transaction engine. Consumes the CR FSM request (cr_transaction_vld/cmd/address/len/data).
// - Builds the DP native AUX request byte stream toward the AUX PHY serializer and parses the reply.
// - Returns ctrl_ack_flag or ctrl_native_failed to the CR FSM.
// - Handles DEFER and timeout retries and buffers write data so it can be retransmitted.

---
 rtl/aux_pkg.sv | 25 ++
 rtl/aux_byte_buf.sv | 46 ++++
 rtl/aux_native_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_aux_native_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_pkg.sv
// Shared types and encodings for the DP native AUX transaction engine.
package aux_pkg;

    typedef enum logic [2:0] {
        IDLE, COLLECT, SEND_HDR, SEND_DATA, WAIT_REPLY, RX_DATA, DRAIN, FAIL
    } aux_state_e;

    localparam logic [3:0] AUX_NATIVE_WR = 4'b1000;
    localparam logic [3:0] AUX_NATIVE_RD = 4'b1001;

    localparam logic [1:0] REPLY_ACK   = 2'b00;
    localparam logic [1:0] REPLY_NACK  = 2'b01;
    localparam logic [1:0] REPLY_DEFER = 2'b10;
    localparam logic [1:0] REPLY_ERR   = 2'b11;

    localparam logic [1:0] CR_CMD_WR = 2'b00;
    localparam logic [1:0] CR_CMD_RD = 2'b01;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [19:0] addr;
        logic [7:0]  len;
    } cr_req_t;

endpackage

// File: rtl/aux_byte_buf.sv
// Payload byte store shared by write retransmission and read reply capture.
module aux_byte_buf #(
    parameter int BUF_DEPTH = 16,
    parameter int IDX_W     = $clog2(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_clr,
    input  logic [7:0]       wr_data,
    input  logic             rd_adv,
    input  logic             rd_rewind,
    output logic [7:0]       rd_data,
    output logic [IDX_W-1:0] wr_ptr,
    output logic [IDX_W-1:0] rd_ptr
);

    logic [BUF_DEPTH-1:0][7:0] mem;
    logic [IDX_W-1:0]          wr_idx;

    // wr_clr together with wr_en stores at slot 0, so a fresh fill needs no idle cycle
    assign wr_idx  = wr_clr ? '0 : wr_ptr;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_idx + 1'b1;
            else if (wr_clr)
                wr_ptr <= '0;
            if (rd_rewind)
                rd_ptr <= '0;
            else if (rd_adv)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/aux_native_ctrl.sv
// Native AUX request/reply engine: builds the request stream, parses the reply,
// retries on DEFER or reply timeout and reports ack/failure to the CR FSM.
module aux_native_ctrl
    import aux_pkg::*;
#(
    parameter int MAX_RETRY     = 7,
    parameter int REPLY_TIMEOUT = 400,
    parameter int BUF_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cr_transaction_vld,
    input  logic [1:0]  cr_cmd,
    input  logic [19:0] cr_address,
    input  logic [7:0]  cr_len,
    input  logic [7:0]  cr_data,
    output logic        aux_tx_vld,
    output logic [7:0]  aux_tx_data,
    output logic        aux_tx_last,
    input  logic        aux_tx_rdy,
    input  logic        aux_rx_vld,
    input  logic [7:0]  aux_rx_data,
    input  logic        aux_rx_last,
    output logic        ctrl_ack_flag,
    output logic        ctrl_native_failed,
    output logic [7:0]  ctrl_rd_data,
    output logic        ctrl_rd_data_vld
);

    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam int TMR_W = $clog2(REPLY_TIMEOUT);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [7:0]       LEN_MAX  = 8'(BUF_DEPTH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REPLY_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    aux_state_e       state, state_n;
    cr_req_t          req;
    logic [1:0]       hdr_idx;
    logic [TMR_W-1:0] timer;
    logic [RTY_W-1:0] retry_cnt;
    logic             ack_q;

    logic req_ld, hdr_clr, hdr_inc, tmr_clr, tmr_run, rty_clr, rty_inc, ack_set, take_retry;
    logic buf_wr_en, buf_wr_clr, buf_rd_adv, buf_rd_rewind;
    logic [7:0]       buf_wr_data, buf_rd_data, hdr_byte;
    logic [IDX_W-1:0] wr_ptr, rd_ptr, len_idx;
    logic             is_rd, tx_hs;

    assign len_idx     = req.len[IDX_W-1:0];
    assign is_rd       = (req.cmd == CR_CMD_RD);
    assign tx_hs       = aux_tx_vld & aux_tx_rdy;
    assign buf_wr_data = (state == RX_DATA) ? aux_rx_data : cr_data;

    aux_byte_buf #(.BUF_DEPTH(BUF_DEPTH), .IDX_W(IDX_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (buf_wr_en),
        .wr_clr    (buf_wr_clr),
        .wr_data   (buf_wr_data),
        .rd_adv    (buf_rd_adv),
        .rd_rewind (buf_rd_rewind),
        .rd_data   (buf_rd_data),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr)
    );

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            2'd0: hdr_byte = {(is_rd ? AUX_NATIVE_RD : AUX_NATIVE_WR), req.addr[19:16]};
            2'd1: hdr_byte = req.addr[15:8];
            2'd2: hdr_byte = req.addr[7:0];
            2'd3: hdr_byte = req.len;
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            hdr_idx   <= '0;
            timer     <= '0;
            retry_cnt <= '0;
            ack_q     <= 1'b0;
        end else begin
            state <= state_n;
            ack_q <= ack_set;
            if (req_ld)
                req <= {cr_cmd, cr_address, cr_len};
            if (hdr_clr)
                hdr_idx <= '0;
            else if (hdr_inc)
                hdr_idx <= hdr_idx + 1'b1;
            if (tmr_clr)
                timer <= '0;
            else if (tmr_run && timer != '1)
                timer <= timer + 1'b1;
            if (rty_clr)
                retry_cnt <= '0;
            else if (rty_inc)
                retry_cnt <= retry_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n       = state;
        req_ld        = 1'b0;
        hdr_clr       = 1'b0;
        hdr_inc       = 1'b0;
        tmr_clr       = 1'b0;
        tmr_run       = 1'b0;
        rty_clr       = 1'b0;
        rty_inc       = 1'b0;
        ack_set       = 1'b0;
        take_retry    = 1'b0;
        buf_wr_en     = 1'b0;
        buf_wr_clr    = 1'b0;
        buf_rd_adv    = 1'b0;
        buf_rd_rewind = 1'b0;

        case (state)
            IDLE: begin
                if (cr_transaction_vld) begin
                    req_ld  = 1'b1;
                    rty_clr = 1'b1;
                    if (cr_len > LEN_MAX || cr_cmd[1]) begin
                        state_n = FAIL;
                    end else if (cr_cmd == CR_CMD_WR) begin
                        buf_wr_en  = 1'b1;
                        buf_wr_clr = 1'b1;
                        // single-byte write is already complete after byte 0
                        if (cr_len == 8'd0) begin
                            state_n       = SEND_HDR;
                            hdr_clr       = 1'b1;
                            buf_rd_rewind = 1'b1;
                        end else begin
                            state_n = COLLECT;
                        end
                    end else begin
                        state_n       = SEND_HDR;
                        hdr_clr       = 1'b1;
                        buf_rd_rewind = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (!cr_transaction_vld) begin
                    state_n = FAIL;
                end else begin
                    buf_wr_en = 1'b1;
                    if (wr_ptr == len_idx) begin
                        state_n       = SEND_HDR;
                        hdr_clr       = 1'b1;
                        buf_rd_rewind = 1'b1;
                    end
                end
            end
            SEND_HDR: begin
                if (tx_hs) begin
                    if (hdr_idx == 2'd3) begin
                        state_n = is_rd ? WAIT_REPLY : SEND_DATA;
                        tmr_clr = is_rd;
                    end else begin
                        hdr_inc = 1'b1;
                    end
                end
            end
            SEND_DATA: begin
                if (tx_hs) begin
                    buf_rd_adv = 1'b1;
                    if (rd_ptr == len_idx) begin
                        state_n = WAIT_REPLY;
                        tmr_clr = 1'b1;
                    end
                end
            end
            WAIT_REPLY: begin
                if (aux_rx_vld) begin
                    case (aux_rx_data[5:4])
                        REPLY_ACK: begin
                            if (is_rd) begin
                                state_n    = aux_rx_last ? FAIL : RX_DATA;
                                buf_wr_clr = 1'b1;
                            end else if (aux_rx_last) begin
                                state_n = IDLE;
                                ack_set = 1'b1;
                            end else begin
                                state_n = FAIL;
                            end
                        end
                        REPLY_DEFER: take_retry = 1'b1;
                        default:     state_n = FAIL;
                    endcase
                end else if (timer == TMR_LAST) begin
                    take_retry = 1'b1;
                end else begin
                    tmr_run = 1'b1;
                end
            end
            RX_DATA: begin
                if (aux_rx_vld) begin
                    buf_wr_en = 1'b1;
                    if (wr_ptr == len_idx) begin
                        state_n       = aux_rx_last ? DRAIN : FAIL;
                        buf_rd_rewind = 1'b1;
                    end else if (aux_rx_last) begin
                        state_n = FAIL;
                    end
                end
            end
            DRAIN: begin
                buf_rd_adv = 1'b1;
                if (rd_ptr == len_idx) begin
                    state_n = IDLE;
                    ack_set = 1'b1;
                end
            end
            FAIL: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // DEFER and timeout share one retry path; data is replayed from the buffer
        if (take_retry) begin
            if (retry_cnt == RTY_MAX) begin
                state_n = FAIL;
            end else begin
                state_n       = SEND_HDR;
                rty_inc       = 1'b1;
                hdr_clr       = 1'b1;
                buf_rd_rewind = 1'b1;
            end
        end
    end

    assign aux_tx_vld         = (state == SEND_HDR) || (state == SEND_DATA);
    assign aux_tx_data        = (state == SEND_HDR)  ? hdr_byte :
                                (state == SEND_DATA) ? buf_rd_data : 8'h00;
    assign aux_tx_last        = ((state == SEND_HDR) && hdr_idx == 2'd3 && is_rd) ||
                                ((state == SEND_DATA) && rd_ptr == len_idx);
    assign ctrl_ack_flag      = ack_q;
    assign ctrl_native_failed = (state == FAIL);
    assign ctrl_rd_data_vld   = (state == DRAIN);
    assign ctrl_rd_data       = (state == DRAIN) ? buf_rd_data : 8'h00;

endmodule

// File: tb/tb_aux_native_ctrl.sv
// Directed table-driven bench for aux_native_ctrl with a serializer/reply model.
module tb_aux_native_ctrl;

    localparam int REPLY_TIMEOUT = 400;
    localparam int BUDGET        = 6000;
    localparam int R_ACK = 0, R_NACK = 1, R_NONE = 2, R_ERR = 3, R_SHORT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cr_transaction_vld = 1'b0;
    logic [1:0]  cr_cmd = '0;
    logic [19:0] cr_address = '0;
    logic [7:0]  cr_len = '0;
    logic [7:0]  cr_data = '0;
    logic        aux_tx_vld, aux_tx_last;
    logic [7:0]  aux_tx_data;
    logic        aux_tx_rdy = 1'b0;
    logic        aux_rx_vld = 1'b0;
    logic [7:0]  aux_rx_data = '0;
    logic        aux_rx_last = 1'b0;
    logic        ctrl_ack_flag, ctrl_native_failed, ctrl_rd_data_vld;
    logic [7:0]  ctrl_rd_data;
    logic [19:0] outs;

    int checks = 0;
    int passes = 0;

    aux_native_ctrl #(.MAX_RETRY(7), .REPLY_TIMEOUT(REPLY_TIMEOUT), .BUF_DEPTH(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .cr_transaction_vld (cr_transaction_vld),
        .cr_cmd             (cr_cmd),
        .cr_address         (cr_address),
        .cr_len             (cr_len),
        .cr_data            (cr_data),
        .aux_tx_vld         (aux_tx_vld),
        .aux_tx_data        (aux_tx_data),
        .aux_tx_last        (aux_tx_last),
        .aux_tx_rdy         (aux_tx_rdy),
        .aux_rx_vld         (aux_rx_vld),
        .aux_rx_data        (aux_rx_data),
        .aux_rx_last        (aux_rx_last),
        .ctrl_ack_flag      (ctrl_ack_flag),
        .ctrl_native_failed (ctrl_native_failed),
        .ctrl_rd_data       (ctrl_rd_data),
        .ctrl_rd_data_vld   (ctrl_rd_data_vld)
    );

    always #5 clk = ~clk;

    assign outs = {aux_tx_vld, aux_tx_last, aux_tx_data, ctrl_ack_flag,
                   ctrl_native_failed, ctrl_rd_data_vld, ctrl_rd_data};

    typedef struct packed {
        logic [1:0]       cmd;
        logic [19:0]      addr;
        logic [7:0]       len;
        logic [0:15][7:0] wdata;    // write payload, or read reply payload
        logic [31:0]      exp_hdr;  // hand-computed 4 header bytes, first byte in [31:24]
        logic [2:0]       reply;    // reply after the DEFERs
        logic [3:0]       n_defer;
        logic [3:0]       exp_att;
        logic             exp_ack;
        logic             exp_tmo;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] cmd, input logic [19:0] addr, input logic [7:0] len,
                                input logic [31:0] hdr, input int reply, input int ndef, input int att,
                                input logic ack, input logic tmo);
        vec_t v;
        v         = '0;
        v.cmd     = cmd;
        v.addr    = addr;
        v.len     = len;
        v.exp_hdr = hdr;
        v.reply   = 3'(reply);
        v.n_defer = 4'(ndef);
        v.exp_att = 4'(att);
        v.exp_ack = ack;
        v.exp_tmo = tmo;
        return v;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        logic [8:0] rxq[$];
        int  ntx, hold, att, txpos, tx_err, rdn, rd_err, both, gap_err, last_hs, last_rd, rx_wait, a, exp_rd;
        logic done, ack_seen, fail_seen, first_pending;
        logic [1:0] post;
        ntx  = (v.cmd == 2'b00) ? 5 + int'(v.len) : 4;
        hold = (v.cmd == 2'b00 && v.len < 8'd16) ? int'(v.len) + 1 : 1;
        att = 0; txpos = 0; tx_err = 0; rdn = 0; rd_err = 0; both = 0; gap_err = 0;
        last_hs = 0; last_rd = -10; rx_wait = 0;
        done = 1'b0; ack_seen = 1'b0; fail_seen = 1'b0; first_pending = 1'b0;
        @(negedge clk);
        for (int c = 0; c < BUDGET && !done; c++) begin
            cr_cmd     = v.cmd;
            cr_address = v.addr;
            cr_len     = v.len;
            cr_transaction_vld = (c < hold);
            if (c < hold) cr_data = v.wdata[c];
            else          cr_data = 8'h00;

            if (rx_wait > 0) begin
                rx_wait--;
                aux_rx_vld = 1'b0;
            end else if (rxq.size() > 0) begin
                {aux_rx_last, aux_rx_data} = rxq.pop_front();
                aux_rx_vld = 1'b1;
            end else begin
                aux_rx_vld = 1'b0;
            end

            aux_tx_rdy = ($urandom_range(0, 3) != 0);
            if (aux_tx_vld && first_pending) begin
                first_pending = 1'b0;
                if (v.exp_tmo && (c - last_hs) != REPLY_TIMEOUT + 1) gap_err++;
            end
            if (aux_tx_vld && aux_tx_rdy) begin
                if (txpos < 4) begin
                    if (aux_tx_data != v.exp_hdr[31 - 8*txpos -: 8]) tx_err++;
                end else if (aux_tx_data != v.wdata[txpos - 4]) tx_err++;
                if (aux_tx_last != (txpos == ntx - 1)) tx_err++;
                txpos++;
                if (txpos == ntx) begin
                    a = att;
                    att++;
                    txpos = 0;
                    last_hs = c;
                    first_pending = 1'b1;
                    rx_wait = 2;
                    if (a < int'(v.n_defer)) rxq.push_back({1'b1, 8'h20});
                    else case (int'(v.reply))
                        R_ACK: begin
                            if (v.cmd == 2'b00) rxq.push_back({1'b1, 8'h00});
                            else begin
                                rxq.push_back({1'b0, 8'h00});
                                for (int k = 0; k <= int'(v.len); k++)
                                    rxq.push_back({k == int'(v.len), v.wdata[k]});
                            end
                        end
                        R_NACK: rxq.push_back({1'b1, 8'h10});
                        R_ERR:  rxq.push_back({1'b1, 8'h30});
                        R_SHORT: begin
                            if (v.cmd == 2'b00) begin
                                rxq.push_back({1'b0, 8'h00});
                                rxq.push_back({1'b1, 8'h00});
                            end else begin
                                rxq.push_back({v.len == 8'd0, 8'h00});
                                for (int k = 0; k < int'(v.len); k++)
                                    rxq.push_back({k == int'(v.len) - 1, v.wdata[k]});
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (ctrl_rd_data_vld) begin
                if (rdn > 15 || ctrl_rd_data != v.wdata[rdn]) rd_err++;
                if (rdn > 0 && c != last_rd + 1) rd_err++;
                last_rd = c;
                rdn++;
            end
            if (ctrl_ack_flag && ctrl_native_failed) both++;
            if (ctrl_ack_flag || ctrl_native_failed) begin
                done      = 1'b1;
                ack_seen  = ctrl_ack_flag;
                fail_seen = ctrl_native_failed;
                if (ctrl_ack_flag && rdn > 0 && c != last_rd + 1) rd_err++;
                if (ctrl_native_failed && first_pending && v.exp_tmo && (c - last_hs) != REPLY_TIMEOUT + 1)
                    gap_err++;
            end
            @(negedge clk);
        end
        cr_transaction_vld = 1'b0;
        aux_rx_vld = 1'b0;
        aux_rx_last = 1'b0;
        aux_tx_rdy = 1'b0;
        post = {ctrl_ack_flag, ctrl_native_failed};
        rxq.delete();
        exp_rd = (v.exp_ack && v.cmd == 2'b01) ? int'(v.len) + 1 : 0;
        check("outcome", id, 32'({ack_seen, fail_seen}), v.exp_ack ? 32'h2 : 32'h1);
        check("attempts", id, 32'(att), 32'(v.exp_att));
        check("tx_stream", id, 32'(tx_err + txpos), 32'h0);
        check("rd_count", id, 32'(rdn), 32'(exp_rd));
        check("rd_bytes", id, 32'(rd_err), 32'h0);
        check("pulse", id, 32'(both) | 32'(post), 32'h0);
        if (v.exp_tmo) check("timeout_gap", id, 32'(gap_err), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_send();
        logic hit;
        hit = 1'b0;
        @(negedge clk);
        cr_cmd = 2'b00; cr_address = 20'h00103; cr_len = 8'd1;
        aux_tx_rdy = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin
            cr_transaction_vld = (c < 2);
            cr_data = (c == 0) ? 8'hA5 : 8'h5A;
            if (aux_tx_vld && aux_tx_last) hit = 1'b1;
            else @(negedge clk);
        end
        check("reach_send_data", 100, 32'(hit), 32'h1);
        aux_tx_rdy = 1'b0;
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", 100, 32'(outs), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", 100, 32'(outs), 32'h0);
        run_vec(101, tbl[0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        repeat (3) @(negedge clk);
        check("reset_outputs", 0, 32'(outs), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 0, 32'(outs), 32'h0);

        v = mk(2'b00, 20'h00103, 8'd1, 32'h80010301, R_ACK, 0, 1, 1'b1, 1'b0);
        v.wdata[0] = 8'hA5; v.wdata[1] = 8'h5A;
        tbl[0] = v;
        v = mk(2'b01, 20'h00202, 8'd5, 32'h90020205, R_ACK, 0, 1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) v.wdata[k] = 8'(k + 1);
        tbl[1] = v;
        v = tbl[0]; v.n_defer = 4'd3; v.exp_att = 4'd4; tbl[2] = v;
        v = tbl[0]; v.n_defer = 4'd8; v.exp_att = 4'd8; v.exp_ack = 1'b0; tbl[3] = v;
        v = tbl[1]; v.reply = 3'(R_NONE); v.exp_att = 4'd8; v.exp_ack = 1'b0; v.exp_tmo = 1'b1; tbl[4] = v;
        v = tbl[0]; v.reply = 3'(R_NACK); v.exp_ack = 1'b0; tbl[5] = v;
        tbl[6] = mk(2'b01, 20'h00202, 8'd16, 32'h0, R_ACK, 0, 0, 1'b0, 1'b0);
        tbl[7] = mk(2'b10, 20'h00103, 8'd0, 32'h0, R_ACK, 0, 0, 1'b0, 1'b0);
        tbl[8] = mk(2'b01, 20'h00202, 8'd1, 32'h90020201, R_ERR, 0, 1, 1'b0, 1'b0);
        v = mk(2'b00, 20'hFABCD, 8'd0, 32'h8FABCD00, R_ACK, 0, 1, 1'b1, 1'b0);
        v.wdata[0] = 8'h3C; tbl[9] = v;
        v = mk(2'b01, 20'h00010, 8'd0, 32'h90001000, R_ACK, 0, 1, 1'b1, 1'b0);
        v.wdata[0] = 8'h77; tbl[10] = v;
        v = mk(2'b01, 20'h00300, 8'd2, 32'h90030002, R_SHORT, 0, 1, 1'b0, 1'b0);
        v.wdata[0] = 8'h11; v.wdata[1] = 8'h22; v.wdata[2] = 8'h33; tbl[11] = v;
        v = tbl[0]; v.reply = 3'(R_SHORT); v.exp_ack = 1'b0; tbl[12] = v;
        v = mk(2'b00, 20'h12345, 8'd15, 32'h8123450F, R_ACK, 1, 2, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) v.wdata[k] = 8'(k * 17);
        tbl[13] = v;

        for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);
        reset_mid_send();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
